data_mem_responder: RTL and testbench

Multi-cycle data memory that answers load/store requests from the pipelined CPU's MEM stage over a request/ready handshake. It replaces the single-cycle data memory when the CPU must stall on memory. It accepts one word-aligned access at a time, completes it after a fixed, parameterised latency and returns read data with a one-cycle completion pulse. It sits between the EX/MEM pipeline register outputs and the MEM/WB pipeline register inputs; the CPU's hazard unit stalls on `busy_o`.

---
 rtl/data_mem_responder_if.sv | 22 ++
 rtl/data_mem_responder.sv | 112 +++++++++++
 tb/tb_data_mem_responder.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the MEM-stage initiator and the multi-cycle data memory.
// Signal names carry the direction as seen from the responder.
interface data_mem_responder_if;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        ready_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        busy_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i,
        input  ready_o, rdata_o, err_o, busy_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i,
        output ready_o, rdata_o, err_o, busy_o
    );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle word-addressed data memory: one access in flight, completes LATENCY edges
// after acceptance with a registered one-cycle ready pulse, error flag and read data.
module data_mem_responder #(
    parameter int unsigned DEPTH   = 128,
    parameter int unsigned LATENCY = 2
) (
    input logic                 clk_i,
    input logic                 rst_i,
    data_mem_responder_if.slave bus
);
    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [29:0] DEPTH_W  = 30'(DEPTH);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           we_q;
    logic [31:0]    addr_q;
    logic [31:0]    wdata_q;
    logic           ready_q, ready_d;
    logic           err_q, err_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           mem_we;
    logic           bad_addr;
    logic [AW-1:0]  mem_idx;
    logic [31:0]    mem_q [DEPTH];

    assign mem_idx  = addr_q[AW+1:2];
    assign bad_addr = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= DEPTH_W);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            if (state_q == IDLE && bus.req_i) begin
                we_q    <= bus.we_i;
                addr_q  <= bus.addr_i;
                wdata_q <= bus.wdata_i;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.req_i) state_d = BUSY;
            BUSY:    if (cnt_q == 4'd0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Completion side effects are decided here so that ready/err/rdata and the
    // memory write all land on the same edge that returns the FSM to IDLE.
    always_comb begin
        cnt_d   = cnt_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_i) cnt_d = CNT_INIT;
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    ready_d = 1'b1;
                    if (bad_addr) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else if (we_q) begin
                        mem_we = 1'b1;
                    end else begin
                        rdata_d = mem_q[mem_idx];
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (mem_we) begin
            mem_q[mem_idx] <= wdata_q;
        end
    end

    assign bus.ready_o = ready_q;
    assign bus.err_o   = err_q;
    assign bus.rdata_o = rdata_q;
    assign bus.busy_o  = (state_q == BUSY);
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a LATENCY=2 and a LATENCY=1 instance driven
// from a vector table, plus hand-written back-to-back, ignored-request and reset sequences.
module tb_data_mem_responder;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    data_mem_responder_if b2();
    data_mem_responder_if b1();

    data_mem_responder #(.DEPTH(128), .LATENCY(2)) dut2 (.clk_i(clk), .rst_i(rst_n), .bus(b2));
    data_mem_responder #(.DEPTH(128), .LATENCY(1)) dut1 (.clk_i(clk), .rst_i(rst_n), .bus(b1));

    typedef struct {
        bit          lat1;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input bit lat1, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (lat1) begin
            b1.req_i = req; b1.we_i = we; b1.addr_i = addr; b1.wdata_i = wdata;
        end else begin
            b2.req_i = req; b2.we_i = we; b2.addr_i = addr; b2.wdata_i = wdata;
        end
    endtask

    function automatic logic f_ready(input bit lat1);
        return lat1 ? b1.ready_o : b2.ready_o;
    endfunction
    function automatic logic f_busy(input bit lat1);
        return lat1 ? b1.busy_o : b2.busy_o;
    endfunction
    function automatic logic f_err(input bit lat1);
        return lat1 ? b1.err_o : b2.err_o;
    endfunction
    function automatic logic [31:0] f_rdata(input bit lat1);
        return lat1 ? b1.rdata_o : b2.rdata_o;
    endfunction

    // One request pulse, then count edges to ready and cycles spent busy.
    task automatic run_txn(input vec_t v, input string tag);
        int cyc;
        int busyc;
        int lat;
        lat = v.lat1 ? 1 : 2;
        @(negedge clk);
        drive(v.lat1, 1'b1, v.we, v.addr, v.wdata);
        @(negedge clk);
        drive(v.lat1, 1'b0, ~v.we, ~v.addr, ~v.wdata);
        cyc   = 0;
        busyc = f_busy(v.lat1) ? 1 : 0;
        while (!f_ready(v.lat1) && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (f_busy(v.lat1)) busyc++;
        end
        check({tag, "_latency"}, cyc, lat);
        check({tag, "_busycycles"}, busyc, lat);
        check({tag, "_err"}, f_err(v.lat1), v.exp_err);
        check({tag, "_rdata"}, f_rdata(v.lat1), v.exp_rdata);
        @(negedge clk);
        check({tag, "_ready_clear"}, f_ready(v.lat1), 1'b0);
    endtask

    initial begin
        int nready;
        vec_t t;

        vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
        vecs[1]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b0, 1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'h0000_0000};
        vecs[3]  = '{1'b0, 1'b1, 32'h0000_0200, 32'hCAFE_F00D, 1'b1, 32'h0000_0000};
        vecs[4]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h0000_0000};
        vecs[5]  = '{1'b0, 1'b1, 32'h0000_01FC, 32'h1234_5678, 1'b0, 32'h0000_0000};
        vecs[6]  = '{1'b0, 1'b0, 32'h0000_01FC, 32'h0,         1'b0, 32'h1234_5678};
        vecs[7]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[8]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hA5A5_A5A5, 1'b0, 32'hDEAD_BEEF};
        vecs[9]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hA5A5_A5A5};
        vecs[10] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0000_0000};
        vecs[11] = '{1'b0, 1'b1, 32'h0000_0002, 32'h0000_0001, 1'b1, 32'h0000_0000};
        vecs[12] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h0000_0000};
        vecs[13] = '{1'b1, 1'b1, 32'h0000_0008, 32'h0000_0077, 1'b0, 32'h0000_0000};
        vecs[14] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,         1'b0, 32'h0000_0077};
        vecs[15] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0,         1'b1, 32'h0000_0000};
        vecs[16] = '{1'b1, 1'b0, 32'h0000_01FC, 32'h0,         1'b0, 32'h0000_0000};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge clk);
        check("rst_ready", b2.ready_o, 1'b0);
        check("rst_err",   b2.err_o,   1'b0);
        check("rst_busy",  b2.busy_o,  1'b0);
        check("rst_rdata", b2.rdata_o, 32'h0);
        check("rst_busy_l1", b1.busy_o, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back stores with req held high: accepts at E0, E3, E6.
        nready = 0;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 32'h0, 32'h1);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check($sformatf("b2b_busy%0d", i),  b2.busy_o,  (i % 3) != 2);
            check($sformatf("b2b_ready%0d", i), b2.ready_o, (i % 3) == 2);
            if (b2.ready_o) nready++;
            if (i == 0)      drive(1'b0, 1'b1, 1'b1, 32'h4, 32'h2);
            else if (i == 3) drive(1'b0, 1'b1, 1'b1, 32'h8, 32'h3);
            else if (i == 6) drive(1'b0, 1'b0, 1'b0, '0, '0);
        end
        check("b2b_ready_count", nready, 3);
        t = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h1}; run_txn(t, "b2b_ld0");
        t = '{1'b0, 1'b0, 32'h4, 32'h0, 1'b0, 32'h2}; run_txn(t, "b2b_ld4");
        t = '{1'b0, 1'b0, 32'h8, 32'h0, 1'b0, 32'h3}; run_txn(t, "b2b_ld8");

        // A request pulsed while busy is dropped, not queued.
        t = '{1'b0, 1'b1, 32'h40, 32'h1111_1111, 1'b0, 32'h3}; run_txn(t, "ign_st");
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'h40, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 32'h44, 32'h0000_0BAD);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        check("ign_busy_e1", b2.busy_o, 1'b1);
        @(negedge clk);
        check("ign_ready", b2.ready_o, 1'b1);
        check("ign_err",   b2.err_o,   1'b0);
        check("ign_rdata", b2.rdata_o, 32'h1111_1111);
        nready = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (b2.ready_o || b2.busy_o) nready++;
        end
        check("ign_no_extra", nready, 0);
        t = '{1'b0, 1'b0, 32'h44, 32'h0, 1'b0, 32'h0}; run_txn(t, "ign_ld44");

        // Reset one cycle after accepting a store: nothing completes, memory cleared.
        t = '{1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 32'h1111_1111}; run_txn(t, "pre_rst_ld");
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 32'h20, 32'h55);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        check("mid_busy", b2.busy_o, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy",  b2.busy_o,  1'b0);
        check("mid_rst_ready", b2.ready_o, 1'b0);
        check("mid_rst_rdata", b2.rdata_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        nready = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (b2.ready_o || b2.busy_o) nready++;
        end
        check("mid_rst_no_ready", nready, 0);
        t = '{1'b0, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0}; run_txn(t, "post_rst_ld20");
        t = '{1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0}; run_txn(t, "post_rst_ld40");
        t = '{1'b1, 1'b0, 32'h08, 32'h0, 1'b0, 32'h0}; run_txn(t, "post_rst_l1_ld8");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
